com_bus_arbiter_param: RTL and testbench

Parametrised successor to the fixed 8-processor/4-snoop common-bus arbiter in the multi-core MESI cache system.
- Grants exclusive ownership of the common bus (Address_Com/Data_Bus_Com) to one processor-side cache controller at a time, using fair round-robin.
- Inside that ownership, grants snoop-response slots to other caches and to the memory snoop path.
- Adds what the fixed arbiter lacks: parametrised channel counts, nested snoop arbitration, an owner-ID output, and a hold-timeout watchdog.

---
 rtl/com_bus_arbiter_param_if.sv | 41 ++++
 rtl/com_bus_arbiter_param.sv | 166 ++++++++++++++++
 tb/tb_com_bus_arbiter_param.sv | 208 ++++++++++++++++++++
 3 files changed

// File: rtl/com_bus_arbiter_param_if.sv
// Common-bus arbitration bundle: processor/snoop/memory requests toward the arbiter
// and the registered grants, owner ID and watchdog pulse coming back from it.
interface com_bus_arbiter_param_if #(
    parameter int NUM_PROC  = 8,
    parameter int NUM_SNOOP = 4,
    parameter int IDW       = $clog2(NUM_PROC)
);
    logic [NUM_PROC-1:0]  Com_Bus_Req_proc;
    logic [NUM_SNOOP-1:0] Com_Bus_Req_snoop;
    logic                 Mem_snoop_req;
    logic [NUM_PROC-1:0]  Com_Bus_Gnt_proc;
    logic [NUM_SNOOP-1:0] Com_Bus_Gnt_snoop;
    logic                 Mem_snoop_gnt;
    logic                 bus_busy;
    logic [IDW-1:0]       gnt_id;
    logic                 timeout_err;

    modport master (
        output Com_Bus_Req_proc,
        output Com_Bus_Req_snoop,
        output Mem_snoop_req,
        input  Com_Bus_Gnt_proc,
        input  Com_Bus_Gnt_snoop,
        input  Mem_snoop_gnt,
        input  bus_busy,
        input  gnt_id,
        input  timeout_err
    );

    modport slave (
        input  Com_Bus_Req_proc,
        input  Com_Bus_Req_snoop,
        input  Mem_snoop_req,
        output Com_Bus_Gnt_proc,
        output Com_Bus_Gnt_snoop,
        output Mem_snoop_gnt,
        output bus_busy,
        output gnt_id,
        output timeout_err
    );
endinterface

// File: rtl/com_bus_arbiter_param.sv
// Round-robin common-bus arbiter: one processor owner at a time, nested round-robin
// snoop-response slots plus a memory slot inside ownership, and a hold-timeout watchdog.
module com_bus_arbiter_param #(
    parameter int NUM_PROC  = 8,
    parameter int NUM_SNOOP = 4,
    parameter int TIMEOUT   = 64,
    parameter int IDW       = $clog2(NUM_PROC)
) (
    input logic clk,
    input logic rst_n,
    com_bus_arbiter_param_if.slave bus
);
    localparam int SW   = (NUM_SNOOP > 1) ? $clog2(NUM_SNOOP) : 1;
    localparam int CW   = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam int TLIM = (TIMEOUT > 0) ? TIMEOUT - 1 : 0;

    typedef enum logic [1:0] {IDLE, OWNED, TURN} state_t;

    state_t               state;
    logic [NUM_PROC-1:0]  gnt_proc;
    logic [NUM_PROC-1:0]  proc_mask;
    logic [NUM_SNOOP-1:0] gnt_snoop;
    logic                 mem_gnt;
    logic                 busy;
    logic                 timeout_err;
    logic [IDW-1:0]       gnt_id;
    logic [IDW-1:0]       proc_ptr;
    logic [SW-1:0]        snoop_ptr;
    logic [CW-1:0]        hold_cnt;

    logic [NUM_PROC-1:0]  proc_elig;
    logic [NUM_PROC-1:0]  proc_rot;
    logic                 proc_found;
    logic [IDW:0]         proc_sum;
    logic [IDW-1:0]       proc_win;
    logic [IDW-1:0]       proc_next;

    logic [NUM_SNOOP-1:0] snoop_rot;
    logic                 snoop_found;
    logic [SW:0]          snoop_sum;
    logic [SW-1:0]        snoop_win;
    logic [SW-1:0]        snoop_next;

    logic                 owner_req;
    logic                 snoop_hold;
    logic                 wd_fire;

    // Rotate the eligible vector so the pointer sits at bit 0; the lowest set bit
    // of the rotated vector, offset by the pointer, is the round-robin winner.
    always_comb begin
        proc_elig  = bus.Com_Bus_Req_proc & ~proc_mask;
        proc_rot   = NUM_PROC'({proc_elig, proc_elig} >> proc_ptr);
        proc_found = 1'b0;
        proc_sum   = '0;
        for (int k = NUM_PROC - 1; k >= 0; k--) begin
            if (proc_rot[k]) begin
                proc_found = 1'b1;
                proc_sum   = {1'b0, proc_ptr} + (IDW+1)'(k);
            end
        end
        if (proc_sum >= (IDW+1)'(NUM_PROC)) begin
            proc_sum = proc_sum - (IDW+1)'(NUM_PROC);
        end
        proc_win  = proc_sum[IDW-1:0];
        proc_next = (proc_win == IDW'(NUM_PROC - 1)) ? '0 : proc_win + IDW'(1);
    end

    always_comb begin
        snoop_rot   = NUM_SNOOP'({bus.Com_Bus_Req_snoop, bus.Com_Bus_Req_snoop} >> snoop_ptr);
        snoop_found = 1'b0;
        snoop_sum   = '0;
        for (int k = NUM_SNOOP - 1; k >= 0; k--) begin
            if (snoop_rot[k]) begin
                snoop_found = 1'b1;
                snoop_sum   = {1'b0, snoop_ptr} + (SW+1)'(k);
            end
        end
        if (snoop_sum >= (SW+1)'(NUM_SNOOP)) begin
            snoop_sum = snoop_sum - (SW+1)'(NUM_SNOOP);
        end
        snoop_win  = snoop_sum[SW-1:0];
        snoop_next = (snoop_win == SW'(NUM_SNOOP - 1)) ? '0 : snoop_win + SW'(1);
    end

    always_comb begin
        owner_req  = |(gnt_proc & bus.Com_Bus_Req_proc);
        snoop_hold = |(gnt_snoop & bus.Com_Bus_Req_snoop);
        wd_fire    = (TIMEOUT > 0) && (hold_cnt == CW'(TLIM));
    end

    // TURN is the zero-grant gap cycle; arbitrating on its exit edge keeps the
    // gap between consecutive owners to exactly one cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            gnt_proc    <= '0;
            gnt_snoop   <= '0;
            mem_gnt     <= 1'b0;
            busy        <= 1'b0;
            gnt_id      <= '0;
            timeout_err <= 1'b0;
            proc_ptr    <= '0;
            snoop_ptr   <= '0;
            proc_mask   <= '0;
            hold_cnt    <= '0;
        end else begin
            timeout_err <= 1'b0;
            proc_mask   <= proc_mask & bus.Com_Bus_Req_proc;
            case (state)
                IDLE, TURN: begin
                    if (proc_found) begin
                        state    <= OWNED;
                        gnt_proc <= NUM_PROC'(1) << proc_win;
                        busy     <= 1'b1;
                        gnt_id   <= proc_win;
                        proc_ptr <= proc_next;
                        hold_cnt <= '0;
                    end else begin
                        state <= IDLE;
                    end
                end
                OWNED: begin
                    if (!owner_req || wd_fire) begin
                        state     <= TURN;
                        gnt_proc  <= '0;
                        gnt_snoop <= '0;
                        mem_gnt   <= 1'b0;
                        busy      <= 1'b0;
                        gnt_id    <= '0;
                        if (owner_req) begin
                            timeout_err <= 1'b1;
                            proc_mask   <= (proc_mask & bus.Com_Bus_Req_proc) | gnt_proc;
                        end
                    end else begin
                        if (TIMEOUT > 0) begin
                            hold_cnt <= hold_cnt + CW'(1);
                        end
                        // Pending snoop responses outrank memory: they may abort the fill.
                        if (mem_gnt) begin
                            if (!bus.Mem_snoop_req) begin
                                mem_gnt <= 1'b0;
                            end
                        end else if (|gnt_snoop) begin
                            if (!snoop_hold) begin
                                gnt_snoop <= '0;
                            end
                        end else if (snoop_found) begin
                            gnt_snoop <= NUM_SNOOP'(1) << snoop_win;
                            snoop_ptr <= snoop_next;
                        end else if (bus.Mem_snoop_req) begin
                            mem_gnt <= 1'b1;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.Com_Bus_Gnt_proc  = gnt_proc;
    assign bus.Com_Bus_Gnt_snoop = gnt_snoop;
    assign bus.Mem_snoop_gnt     = mem_gnt;
    assign bus.bus_busy          = busy;
    assign bus.gnt_id            = gnt_id;
    assign bus.timeout_err       = timeout_err;
endmodule

// File: tb/tb_com_bus_arbiter_param.sv
// Bench for com_bus_arbiter_param: table of single-cycle vectors plus hand-written
// snoop, memory, async-reset, round-robin and watchdog sequences, scored via a queue.
module tb_com_bus_arbiter_param;
    localparam int NP = 8;
    localparam int NS = 4;
    localparam int TO = 64;

    typedef struct packed {
        logic [NP-1:0] gp;
        logic [NS-1:0] gs;
        logic          mg;
        logic          busy;
        logic [2:0]    id;
        logic          terr;
    } out_t;

    typedef struct {
        logic [NP-1:0] p;
        logic [NS-1:0] s;
        logic          m;
        out_t          e;
        string         nm;
    } vec_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    int   checks = 0;
    int   passed = 0;
    out_t  exp_q[$];
    string nm_q[$];
    vec_t  tbl[13];

    always #5 clk = ~clk;

    com_bus_arbiter_param_if #(.NUM_PROC(NP), .NUM_SNOOP(NS)) bus ();

    com_bus_arbiter_param #(
        .NUM_PROC (NP),
        .NUM_SNOOP(NS),
        .TIMEOUT  (TO)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    function automatic out_t own(input int k, input logic [NS-1:0] gs, input logic mg);
        out_t o;
        o      = '0;
        o.gp   = NP'(1) << k;
        o.gs   = gs;
        o.mg   = mg;
        o.busy = 1'b1;
        o.id   = 3'(k);
        return o;
    endfunction

    function automatic out_t tmo();
        out_t o;
        o      = '0;
        o.terr = 1'b1;
        return o;
    endfunction

    function automatic vec_t mkvec(input logic [NP-1:0] p, input logic [NS-1:0] s,
                                   input logic m, input out_t e, input string nm);
        vec_t v;
        v.p  = p;
        v.s  = s;
        v.m  = m;
        v.e  = e;
        v.nm = nm;
        return v;
    endfunction

    task automatic check_output();
        out_t  act;
        out_t  e;
        string nm;
        act = out_t'({bus.Com_Bus_Gnt_proc, bus.Com_Bus_Gnt_snoop, bus.Mem_snoop_gnt,
                      bus.bus_busy, bus.gnt_id, bus.timeout_err});
        checks++;
        if (exp_q.size() == 0) begin
            $display("[TB] FAIL scoreboard_empty: got an output with no expectation queued");
            return;
        end
        e  = exp_q.pop_front();
        nm = nm_q.pop_front();
        if (act === e) begin
            passed++;
        end else begin
            $display("[TB] FAIL %s: got gp=%b gs=%b mg=%b busy=%b id=%0d terr=%b, need gp=%b gs=%b mg=%b busy=%b id=%0d terr=%b",
                     nm, act.gp, act.gs, act.mg, act.busy, act.id, act.terr,
                     e.gp, e.gs, e.mg, e.busy, e.id, e.terr);
        end
    endtask

    task automatic expect_now(input out_t e, input string nm);
        exp_q.push_back(e);
        nm_q.push_back(nm);
    endtask

    task automatic apply_stimulus(input logic [NP-1:0] p, input logic [NS-1:0] s,
                                  input logic m, input out_t e, input string nm);
        bus.Com_Bus_Req_proc  = p;
        bus.Com_Bus_Req_snoop = s;
        bus.Mem_snoop_req     = m;
        expect_now(e, nm);
        @(posedge clk);
        #1;
        check_output();
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL global_timeout: simulation still running at %0t", $time);
        $fatal(1, "[TB] bench did not finish");
    end

    initial begin
        tbl[0]  = mkvec(8'h00, 4'h0, 1'b0, '0,              "idle_after_reset");
        tbl[1]  = mkvec(8'h01, 4'h0, 1'b0, own(0, 4'h0, 0), "grant_core0");
        tbl[2]  = mkvec(8'h01, 4'h0, 1'b0, own(0, 4'h0, 0), "hold_core0");
        tbl[3]  = mkvec(8'h00, 4'h0, 1'b0, '0,              "release_core0");
        tbl[4]  = mkvec(8'h00, 4'h0, 1'b0, '0,              "turn_to_idle");
        tbl[5]  = mkvec(8'h00, 4'hF, 1'b1, '0,              "snoop_ignored_idle");
        tbl[6]  = mkvec(8'h02, 4'hF, 1'b1, own(1, 4'h0, 0), "grant_core1_no_snoop");
        tbl[7]  = mkvec(8'h00, 4'h1, 1'b0, '0,              "release_beats_snoop");
        tbl[8]  = mkvec(8'h00, 4'h1, 1'b0, '0,              "turn_ignores_snoop");
        tbl[9]  = mkvec(8'h00, 4'h0, 1'b0, '0,              "idle_again");
        tbl[10] = mkvec(8'h03, 4'h0, 1'b0, own(0, 4'h0, 0), "ptr_wrap_core0");
        tbl[11] = mkvec(8'h00, 4'h0, 1'b0, '0,              "release_wrap");
        tbl[12] = mkvec(8'h00, 4'h0, 1'b0, '0,              "idle_before_snoop");

        bus.Com_Bus_Req_proc  = '0;
        bus.Com_Bus_Req_snoop = '0;
        bus.Mem_snoop_req     = 1'b0;
        #1 rst_n = 1'b0;
        @(posedge clk);
        #1;
        expect_now('0, "reset_state");
        check_output();
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 13; i++) begin
            apply_stimulus(tbl[i].p, tbl[i].s, tbl[i].m, tbl[i].e, tbl[i].nm);
        end

        // Core 2 owns the bus; snoop requests 1 and 3 are served in turn.
        apply_stimulus(8'h04, 4'h0, 1'b0, own(2, 4'h0, 0), "snp_grant_core2");
        apply_stimulus(8'h04, 4'hA, 1'b0, own(2, 4'h2, 0), "snp_first_bit1");
        apply_stimulus(8'h04, 4'hA, 1'b0, own(2, 4'h2, 0), "snp_hold_bit1");
        apply_stimulus(8'h04, 4'h8, 1'b0, own(2, 4'h0, 0), "snp_bit1_clears");
        apply_stimulus(8'h04, 4'h8, 1'b0, own(2, 4'h8, 0), "snp_next_bit3");
        apply_stimulus(8'h04, 4'h0, 1'b0, own(2, 4'h0, 0), "snp_bit3_clears");

        apply_stimulus(8'h04, 4'h1, 1'b1, own(2, 4'h1, 0), "mem_snoop_first");
        apply_stimulus(8'h04, 4'h1, 1'b1, own(2, 4'h1, 0), "mem_snoop_hold");
        apply_stimulus(8'h04, 4'h0, 1'b1, own(2, 4'h0, 0), "mem_snoop_clears");
        apply_stimulus(8'h04, 4'h0, 1'b1, own(2, 4'h0, 1), "mem_grant_rises");
        apply_stimulus(8'h04, 4'h2, 1'b1, own(2, 4'h0, 1), "mem_blocks_snoop");
        apply_stimulus(8'h04, 4'h2, 1'b0, own(2, 4'h0, 0), "mem_grant_drops");
        apply_stimulus(8'h04, 4'h2, 1'b0, own(2, 4'h2, 0), "snp_after_mem");
        apply_stimulus(8'h04, 4'h0, 1'b1, own(2, 4'h0, 0), "snp_clears_again");
        apply_stimulus(8'h04, 4'h0, 1'b1, own(2, 4'h0, 1), "mem_active_pre_reset");

        #2 rst_n = 1'b0;
        expect_now('0, "async_reset_mid_owned");
        #1;
        check_output();
        bus.Com_Bus_Req_proc  = 8'hFF;
        bus.Com_Bus_Req_snoop = 4'h0;
        bus.Mem_snoop_req     = 1'b0;
        @(posedge clk);
        #1;
        expect_now('0, "reset_held");
        check_output();
        @(negedge clk);
        rst_n = 1'b1;

        for (int k = 0; k < NP; k++) begin
            for (int c = 0; c < 3; c++) begin
                apply_stimulus(8'hFF, 4'h0, 1'b0, own(k, 4'h0, 0), $sformatf("rr_core%0d_cyc%0d", k, c));
            end
            apply_stimulus(8'hFF & ~(NP'(1) << k), 4'h0, 1'b0, '0, $sformatf("rr_gap_after_core%0d", k));
        end
        apply_stimulus(8'hFF, 4'h0, 1'b0, own(0, 4'h0, 0), "rr_wrap_core0");
        apply_stimulus(8'hFE, 4'h0, 1'b0, '0,              "rr_final_release");

        apply_stimulus(8'h20, 4'h0, 1'b0, own(5, 4'h0, 0), "wd_grant_core5");
        for (int i = 1; i < TO; i++) begin
            apply_stimulus(8'h60, 4'h0, 1'b0, own(5, 4'h0, 0), $sformatf("wd_hold_cyc%0d", i));
        end
        apply_stimulus(8'h60, 4'h0, 1'b0, tmo(),           "wd_timeout_pulse");
        apply_stimulus(8'h60, 4'h0, 1'b0, own(6, 4'h0, 0), "wd_grant_moves_core6");
        apply_stimulus(8'h60, 4'h0, 1'b0, own(6, 4'h0, 0), "wd_core6_hold");
        apply_stimulus(8'h20, 4'h0, 1'b0, '0,              "wd_core6_release");
        apply_stimulus(8'h20, 4'h0, 1'b0, '0,              "wd_core5_masked");
        apply_stimulus(8'h20, 4'h0, 1'b0, '0,              "wd_core5_still_masked");
        apply_stimulus(8'h00, 4'h0, 1'b0, '0,              "wd_core5_drops");
        apply_stimulus(8'h20, 4'h0, 1'b0, own(5, 4'h0, 0), "wd_core5_regrant");
        apply_stimulus(8'h00, 4'h0, 1'b0, '0,              "final_release");

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
